gate_stim_gen: RTL and testbench
================================

# gate_stim_gen

Input-stimulus stage that drives the `A`/`B` operands of the two-input logic-gate block. It produces them in one of two ways:
- **Manual:** from two raw board switches, synchronised and debounced.
- **Auto:** from an internal sweep through all four input combinations 00→01→10→11, with a fixed dwell time per vector.

Outputs are registered, glitch-free levels, so the downstream gate outputs can be observed on LEDs or captured by a checker without switch bounce.

## Interface
- `DB_CYCLES`, 16: consecutive stable cycles required to accept a switch change; legal range ≥2.
- `STEP_CYCLES`, 8: cycles each vector is held in auto mode; legal range ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw_a`  in  1  raw switch for operand A; asynchronous and bouncy.
- `sw_b`  in  1  raw switch for operand B; asynchronous and bouncy.
- `mode_auto`  in  1  synchronous level; 1 = auto sweep, 0 = manual switches.
- `A`  out  1  registered operand A to the gate block.
- `B`  out  1  registered operand B to the gate block.
- `vec_idx`  out  2  current auto vector index; equals {A,B} while in auto.
- `vec_change`  out  1  one-cycle pulse, high in the cycle {A,B} takes a new value.

## Operation
- **Reset** (rst=1 at an edge) clears all of the following to 0:
  - both 2-flop synchronisers;
  - debounced values and debounce counters;
  - dwell counter;
  - `vec_idx`, `A`, `B`, `vec_change`.
- **Synchroniser:** `sw_a` and `sw_b` each pass through two flops. Only the second-flop value (`sync_x`) is used downstream.
- **Debounce**, per channel, running every cycle regardless of mode:
  - If `sync_x` == `db_x`: the counter is cleared to 0.
  - Else, if counter == DB_CYCLES-1: `db_x` <= `sync_x` and the counter is cleared.
  - Else: the counter increments.
  - Any bounce back to `db_x` before the count completes restarts the count.
- **Mode tracking:** a registered copy `mode_q` of `mode_auto` is kept.
  - **Entering auto** (`mode_auto`=1, `mode_q`=0): `vec_idx` <= 0, dwell <= 0, {A,B} <= 00.
- **Auto, steady** (`mode_auto`=1, `mode_q`=1):
  - If dwell == STEP_CYCLES-1: dwell <= 0, `vec_idx` <= `vec_idx`+1 mod 4 (3 wraps to 0), {A,B} <= new `vec_idx`.
  - Otherwise dwell increments and {A,B} holds.
- **Manual** (`mode_auto`=0): {A,B} <= {`db_a`,`db_b`}. Dwell and `vec_idx` hold their last values.
- **Change pulse:** `vec_change` <= (next {A,B} != current {A,B}). It is registered alongside A/B, so it is high exactly in the cycle the new value first appears.
- **Mode switch mid-dwell:** the partial dwell is discarded. Re-entry into auto always restarts at vector 0 with a full dwell.
- **Simultaneous change of both switches:** each channel debounces independently. A and B may update on different cycles, producing two separate `vec_change` pulses.

## Timing
- **Manual latency:** a switch level first sampled at edge k and held stable changes A/B at edge k+DB_CYCLES+2.
  - 2 cycles synchroniser;
  - DB_CYCLES−1 count cycles plus the `db_x` update;
  - 1 cycle output register.
- **Auto timing:** entering auto at edge m gives 00 at m, 01 at m+STEP_CYCLES, 10 at m+2·STEP_CYCLES, 11 at m+3·STEP_CYCLES, and 00 again at m+4·STEP_CYCLES.
- **STEP_CYCLES=1:** the vector advances every cycle and `vec_change` stays high continuously.
- **Leaving auto at edge n:** {A,B} equals {`db_a`,`db_b`} at edge n.
- **Reset during operation:** outputs are 0 at the first edge with rst=1 and stay 0 while rst is held. The first auto step after releasing reset with `mode_auto`=1 counts as an entry into auto.
- **No combinational paths** from any input to any output.

## Test plan
Settings: DB_CYCLES=4, STEP_CYCLES=3.
- **Reset:** hold rst 2 cycles with `sw_a`=`sw_b`=1 and `mode_auto`=0 → A=B=0, `vec_idx`=0, `vec_change`=0 throughout reset. After release, A and B rise to 1 together, 6 edges after the first sample, with a single `vec_change` pulse.
- **Bounce rejection:** in manual with A=0, toggle `sw_a` 1,0,1,0 on consecutive cycles, then hold 0 → A stays 0 and `vec_change` never asserts. Then hold `sw_a`=1 → A=1 exactly 6 edges after the first 1 sample, with a one-cycle `vec_change`.
- **Auto sweep and wrap:** assert `mode_auto` at edge m → {A,B} = 00 at m, 01 at m+3, 10 at m+6, 11 at m+9, 00 at m+12; `vec_change` high at m+3, m+6, m+9, m+12 only, plus at m if {A,B} was nonzero before entry.
- **Mode exit/re-entry mid-dwell:** at `vec_idx`=2 with dwell=1, drop `mode_auto` with `db_a`=`db_b`=1 → {A,B}=11 on the next edge and `vec_idx` holds at 2. Reassert → {A,B}=00 and `vec_idx`=0 on the entry edge, with a full 3-cycle dwell before 01.
- **Independent channels:** raise `sw_a` at edge k and `sw_b` at edge k+2 → A rises at k+6 and B rises at k+8, each with its own one-cycle `vec_change` pulse.
- **Reset mid-sweep:** assert rst at `vec_idx`=3 → all outputs 0 on that edge. Release with `mode_auto`=1 → the sweep restarts at 00 and reaches 01 three edges after release.

Source files
------------

// File: rtl/gate_stim_gen.sv
// gate_stim_gen: operand source for the two-input gate block.
// Manual mode passes two synchronised, debounced switches through to A/B.
// Auto mode sweeps {A,B} through 00,01,10,11 with a fixed dwell per vector.
// A, B, vec_idx and vec_change all come straight from flops, so there is no
// combinational path from any input to any output.
module gate_stim_gen #(
   parameter int DB_CYCLES   = 16,
   parameter int STEP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw_a,
   input  logic       sw_b,
   input  logic       mode_auto,
   output logic       A,
   output logic       B,
   output logic [1:0] vec_idx,
   output logic       vec_change
);

   // Counter widths; DB_CYCLES >= 2 so $clog2 is at least 1.
   localparam int CW = $clog2(DB_CYCLES);
   localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(STEP_CYCLES - 1);

   // Channel packing used throughout: bit 1 = A, bit 0 = B.
   logic [1:0]         sync1;
   logic [1:0]         sync2;
   logic [1:0]         db;
   logic [1:0][CW-1:0] db_cnt;
   logic               mode_q;
   logic [DW-1:0]      dwell;
   logic [DW-1:0]      dwell_next;
   logic [1:0]         vec_next;
   logic [1:0]         ab;
   logic [1:0]         ab_next;

   assign A = ab[1];
   assign B = ab[0];

   // Two-flop synchronisers for the asynchronous switch inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {sw_a, sw_b};
         sync2 <= sync1;
      end
   end

   // Per-channel debounce: a new level is accepted only after it has been
   // seen on DB_CYCLES consecutive cycles; any return to the accepted level
   // clears the count. Runs in both modes so manual is ready on exit.
   always_ff @(posedge clk) begin
      if (rst) begin
         db     <= '0;
         db_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Next operand/sweep state. A rising mode_auto (mode_q still 0) restarts
   // the sweep at vector 0 with a full dwell; manual mode freezes dwell and
   // vec_idx and follows the debounced switches.
   always_comb begin
      ab_next    = ab;
      dwell_next = dwell;
      vec_next   = vec_idx;
      if (mode_auto && !mode_q) begin
         ab_next    = 2'b00;
         dwell_next = '0;
         vec_next   = 2'd0;
      end else if (mode_auto) begin
         if (dwell == DWELL_LAST) begin
            dwell_next = '0;
            vec_next   = vec_idx + 2'd1;
            ab_next    = vec_next;
         end else begin
            dwell_next = dwell + 1'b1;
         end
      end else begin
         ab_next = db;
      end
   end

   // Output and sweep registers; vec_change marks the first cycle of a new {A,B}.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= 1'b0;
         dwell      <= '0;
         vec_idx    <= 2'd0;
         ab         <= 2'b00;
         vec_change <= 1'b0;
      end else begin
         mode_q     <= mode_auto;
         dwell      <= dwell_next;
         vec_idx    <= vec_next;
         ab         <= ab_next;
         vec_change <= (ab_next != ab);
      end
   end

endmodule

// File: tb/tb_gate_stim_gen.sv
// tb_gate_stim_gen: directed and randomized checks of gate_stim_gen against a
// reference model that works from switch-level history windows and elapsed
// cycles since entering auto mode.
module tb_gate_stim_gen;

   localparam int DB   = 4;
   localparam int STEP = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sw_a = 1'b0;
   logic       sw_b = 1'b0;
   logic       mode_auto = 1'b0;
   logic       A;
   logic       B;
   logic [1:0] vec_idx;
   logic       vec_change;

   int tests = 0;
   int fails = 0;

   gate_stim_gen #(.DB_CYCLES(DB), .STEP_CYCLES(STEP)) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_a       (sw_a),
      .sw_b       (sw_b),
      .mode_auto  (mode_auto),
      .A          (A),
      .B          (B),
      .vec_idx    (vec_idx),
      .vec_change (vec_change)
   );

   // Clock
   always #5 clk = ~clk;

   // Reference model state
   logic       m_s1_a = 1'b0, m_s1_b = 1'b0;
   logic       m_sync_a = 1'b0, m_sync_b = 1'b0;
   logic       hist_a[$];
   logic       hist_b[$];
   logic       m_db_a = 1'b0, m_db_b = 1'b0;
   logic       m_mode_q = 1'b0;
   int         m_elapsed = 0;
   logic [1:0] m_ab = 2'b00;
   logic [1:0] m_vec = 2'd0;
   logic       m_chg = 1'b0;

   // True when every synchronised sample in the window differs from level.
   function automatic bit window_differs(input logic h[$], input logic level);
      if (h.size() < DB) return 1'b0;
      for (int i = h.size() - DB; i < h.size(); i++)
         if (h[i] == level) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_update();
      logic       old_db_a, old_db_b;
      logic [1:0] old_ab;
      if (rst) begin
         m_s1_a = 0; m_s1_b = 0; m_sync_a = 0; m_sync_b = 0;
         hist_a = {}; hist_b = {};
         for (int i = 0; i < DB; i++) begin hist_a.push_back(1'b0); hist_b.push_back(1'b0); end
         m_db_a = 0; m_db_b = 0; m_mode_q = 0; m_elapsed = 0;
         m_ab = 2'b00; m_vec = 2'd0; m_chg = 1'b0;
         return;
      end
      old_db_a = m_db_a;
      old_db_b = m_db_b;
      old_ab   = m_ab;
      // A level is accepted once the last DB synchronised samples all differ.
      if (window_differs(hist_a, m_db_a)) m_db_a = ~m_db_a;
      if (window_differs(hist_b, m_db_b)) m_db_b = ~m_db_b;
      if (mode_auto) begin
         if (!m_mode_q) m_elapsed = 0;
         else           m_elapsed = m_elapsed + 1;
         m_ab  = 2'((m_elapsed / STEP) % 4);
         m_vec = m_ab;
      end else begin
         m_ab = {old_db_a, old_db_b};
      end
      m_chg    = (m_ab != old_ab);
      m_mode_q = mode_auto;
      // Two-flop delay line, then record the synchronised value.
      m_sync_a = m_s1_a; m_s1_a = sw_a;
      m_sync_b = m_s1_b; m_s1_b = sw_b;
      hist_a.push_back(m_sync_a); void'(hist_a.pop_front());
      hist_b.push_back(m_sync_b); void'(hist_b.pop_front());
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge: advance the model, then compare 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      chk("model_a",   {1'b0, A},          {1'b0, m_ab[1]});
      chk("model_b",   {1'b0, B},          {1'b0, m_ab[0]});
      chk("model_vec", vec_idx,            m_vec);
      chk("model_chg", {1'b0, vec_change}, {1'b0, m_chg});
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int hold;
      for (int i = 0; i < DB; i++) begin hist_a.push_back(1'b0); hist_b.push_back(1'b0); end

      // Reset with both switches high: outputs stay 0, then rise together.
      rst = 1; sw_a = 1; sw_b = 1; mode_auto = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ab",  {A, B}, 2'b00);
         chk("rst_vec", vec_idx, 2'd0);
         chk("rst_chg", {1'b0, vec_change}, 2'b00);
      end
      rst = 0;
      ticks(6);
      chk("rel_ab_early", {A, B}, 2'b00);
      tick();
      chk("rel_ab_rise", {A, B}, 2'b11);
      chk("rel_chg",     {1'b0, vec_change}, 2'b01);
      tick();
      chk("rel_chg_end", {1'b0, vec_change}, 2'b00);

      // Bounce rejection on channel A.
      sw_a = 0;
      ticks(8);
      chk("bnc_a_low", {1'b0, A}, 2'b00);
      sw_a = 1; tick(); sw_a = 0; tick(); sw_a = 1; tick(); sw_a = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("bnc_a_hold", {1'b0, A}, 2'b00);
         chk("bnc_chg",    {1'b0, vec_change}, 2'b00);
      end
      sw_a = 1;
      ticks(6);
      chk("bnc_a_early", {1'b0, A}, 2'b00);
      tick();
      chk("bnc_a_rise", {1'b0, A}, 2'b01);
      chk("bnc_chg_hi", {1'b0, vec_change}, 2'b01);
      tick();
      chk("bnc_chg_lo", {1'b0, vec_change}, 2'b00);

      // Auto sweep and wrap, entered from {A,B}=11.
      mode_auto = 1;
      for (int i = 0; i <= 12; i++) begin
         tick();
         chk("swp_ab",  {A, B}, 2'((i / STEP) % 4));
         chk("swp_chg", {1'b0, vec_change}, {1'b0, (i % STEP) == 0});
      end

      // Exit at vec_idx=2, dwell=1, then re-enter.
      ticks(7);
      chk("mid_vec", vec_idx, 2'd2);
      mode_auto = 0;
      tick();
      chk("exit_ab",  {A, B}, 2'b11);
      chk("exit_vec", vec_idx, 2'd2);
      mode_auto = 1;
      tick();
      chk("reent_ab",  {A, B}, 2'b00);
      chk("reent_vec", vec_idx, 2'd0);
      ticks(2);
      chk("reent_hold", {A, B}, 2'b00);
      tick();
      chk("reent_step", {A, B}, 2'b01);

      // Independent channels: A raised two cycles before B.
      mode_auto = 0; sw_a = 0; sw_b = 0;
      ticks(10);
      chk("ind_zero", {A, B}, 2'b00);
      sw_a = 1;
      for (int t = 1; t <= 10; t++) begin
         if (t == 3) sw_b = 1;
         tick();
         chk("ind_a",   {1'b0, A}, {1'b0, t >= 7});
         chk("ind_b",   {1'b0, B}, {1'b0, t >= 9});
         chk("ind_chg", {1'b0, vec_change}, {1'b0, (t == 7) || (t == 9)});
      end

      // Reset in the middle of a sweep.
      mode_auto = 1;
      ticks(10);
      chk("mr_vec3", vec_idx, 2'd3);
      rst = 1;
      tick();
      chk("mr_rst_ab",  {A, B}, 2'b00);
      chk("mr_rst_vec", vec_idx, 2'd0);
      rst = 0;
      tick();
      chk("mr_entry", {A, B}, 2'b00);
      ticks(2);
      chk("mr_hold", {A, B}, 2'b00);
      tick();
      chk("mr_step", {A, B}, 2'b01);

      // Randomized switches, mode changes and occasional reset.
      for (int n = 0; n < 80; n++) begin
         sw_a = 1'($urandom_range(0, 1));
         sw_b = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) mode_auto = ~mode_auto;
         rst  = ($urandom_range(0, 24) == 0);
         hold = $urandom_range(1, 9);
         ticks(hold);
         rst = 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
